// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] work_q, work_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] part_q, part_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   shifted;
  logic [VW-1:0] diff;
  logic          qbit;
  logic          last_iter;

  // The partial stays below the divisor between iterations, so only the
  // shifted value needs the extra bit; a successful difference fits in VW bits.
  always_comb begin
    shifted   = {part_q, work_q[DW-1]};
    qbit      = (shifted >= {1'b0, dvs_q});
    diff      = shifted[VW-1:0] - dvs_q;
    last_iter = (cnt_q == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor != '0) ? RUN : DONE;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    work_d = work_q;
    dvs_d  = dvs_q;
    part_d = part_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = dividend;
          dvs_d  = divisor;
          part_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
          end
        end
      end
      RUN: begin
        part_d = qbit ? diff : shifted[VW-1:0];
        work_d = {work_q[DW-2:0], qbit};
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          quot_d = {work_q[DW-2:0], qbit};
          rem_d  = qbit ? diff : shifted[VW-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      dvs_q  <= '0;
      part_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      dvs_q  <= dvs_d;
      part_q <= part_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, held start,
// mid-run reset and randomized operations against an arithmetic reference.
module tb_seq_restoring_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] last_q = '0;
  logic [VW-1:0] last_r = '0;
  logic          last_z = 1'b0;

  seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = '0; z = 1'b1;
    end else begin
      q = DW'(int'(a) / int'(b));
      r = VW'(int'(a) % int'(b));
      z = 1'b0;
    end
  endtask

  // Issues one operation from IDLE and checks handshake, latency and results.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input string tag);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int            k;
    int            busy_n;
    model(a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
    if (b != 0) chk({tag, "_hold_q"}, 32'(quotient), 32'(last_q));
    k = 0;
    busy_n = 0;
    while (!done && k < 2 * DW + 4) begin
      if (busy) busy_n++;
      @(negedge clk);
      dividend = DW'($urandom); divisor = VW'($urandom);
      k++;
    end
    chk({tag, "_latency"}, 32'(k + 1), (b == 0) ? 32'd1 : 32'(DW + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_n), (b == 0) ? 32'd0 : 32'(DW));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    if (b != 0) begin
      chk({tag, "_identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk({tag, "_r_lt_d"}, 32'(remainder < b), 32'd1);
    end
    last_q = eq; last_r = er; last_z = ez;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] ha[50];
    logic [VW-1:0] hb[50];
    int ndone;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    do_op(8'd200, 4'd13, "op200_13");
    do_op(8'd255, 4'd1,  "op255_1");
    do_op(8'd7,   4'd9,  "op7_9");
    do_op(8'd225, 4'd15, "op225_15");
    do_op(8'd0,   4'd5,  "op0_5");
    do_op(8'd255, 4'd15, "op255_15");
    do_op(8'd100, 4'd0,  "op100_0");
    do_op(8'd100, 4'd7,  "op100_7");

    // Start held high, operands changing every cycle
    for (int i = 0; i < 50; i++) begin
      ha[i] = DW'($urandom);
      hb[i] = VW'($urandom_range(1, 15));
    end
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      start = 1'b1; dividend = ha[c]; divisor = hb[c];
      @(negedge clk);
      chk("held_done", 32'(done), 32'((c % 10) == 8));
      if (done && c >= 8) begin
        ndone++;
        chk("held_q", 32'(quotient), 32'(int'(ha[c-8]) / int'(hb[c-8])));
        chk("held_r", 32'(remainder), 32'(int'(ha[c-8]) % int'(hb[c-8])));
      end
    end
    start = 1'b0;
    chk("held_count", 32'(ndone), 32'd5);
    last_q = DW'(int'(ha[40]) / int'(hb[40]));
    @(negedge clk);

    // Reset during the 4th RUN cycle
    start = 1'b1; dividend = 8'd200; divisor = 4'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    do_op(8'd50, 4'd7, "op50_7");

    // Randomized operations
    for (int n = 0; n < 1000; n++) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      a = DW'($urandom);
      b = VW'($urandom);
      do_op(a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
